cp0: RTL and testbench

CP0 -- requirements
Module: cp0

---
 rtl/cp0.sv | 98 +++++++++
 tb/tb_cp0.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/cp0.sv
// CP0 system-control coprocessor: SR, Cause, EPC, PRId plus exception/interrupt request logic.
// Ports: clk/reset; mfc0/mtc0 access (RegAddr, WE, Din, Dout); victim info (VPC, BDIn, ExcCodeIn);
//        HWInt lines; EXLClr from eret; Req (take exception now, combinational); EPCOut (eret target).
module cp0 #(
  parameter logic [31:0] PRID = 32'h0000_7f00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  RegAddr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  input  logic [31:0] VPC,
  input  logic        BDIn,
  input  logic [4:0]  ExcCodeIn,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic        Req,
  output logic [31:0] EPCOut
);

  localparam logic [4:0] IDX_SR    = 5'd12;
  localparam logic [4:0] IDX_CAUSE = 5'd13;
  localparam logic [4:0] IDX_EPC   = 5'd14;
  localparam logic [4:0] IDX_PRID  = 5'd15;

  // SR fields
  logic [5:0]  im;
  logic        exl;
  logic        ie;
  // Cause fields
  logic        bd;
  logic [5:0]  ip;
  logic [4:0]  exc_code;
  // EPC is word aligned, so only the upper 30 bits are stored.
  logic [31:2] epc;

  logic        int_req;
  logic        exc_req;
  logic [31:0] sr_val;
  logic [31:0] cause_val;
  logic [31:0] epc_val;

  assign sr_val    = {16'd0, im, 8'd0, exl, ie};
  assign cause_val = {bd, 15'd0, ip, 3'd0, exc_code, 2'd0};
  assign epc_val   = {epc, 2'b00};

  // EXL blocks both sources, so nothing nests inside a handler.
  assign int_req = ie && !exl && (|(HWInt & im));
  assign exc_req = !exl && (ExcCodeIn != 5'd0);
  assign Req     = int_req || exc_req;
  assign EPCOut  = epc_val;

  always_comb begin
    Dout = 32'd0;
    case (RegAddr)
      IDX_SR:    Dout = sr_val;
      IDX_CAUSE: Dout = cause_val;
      IDX_EPC:   Dout = epc_val;
      IDX_PRID:  Dout = PRID;
      default:   Dout = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      im       <= 6'd0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      bd       <= 1'b0;
      ip       <= 6'd0;
      exc_code <= 5'd0;
      epc      <= 30'd0;
    end else begin
      ip <= HWInt;
      if (Req) begin
        // Taking the exception discards the victim's own mtc0.
        exl      <= 1'b1;
        bd       <= BDIn;
        exc_code <= int_req ? 5'd0 : ExcCodeIn;
        // A delay-slot victim restarts at the branch, one word earlier.
        epc      <= VPC[31:2] - {29'd0, BDIn};
      end else begin
        if (WE && (RegAddr == IDX_SR)) begin
          im  <= Din[15:10];
          ie  <= Din[0];
          exl <= Din[1] & ~EXLClr;
        end else if (EXLClr) begin
          exl <= 1'b0;
        end
        if (WE && (RegAddr == IDX_EPC)) begin
          epc <= Din[31:2];
        end
      end
    end
  end

endmodule

// File: tb/tb_cp0.sv
// Bench for cp0: a table of per-cycle vectors (inputs plus expected Req/Dout/EPCOut
// before the edge), followed by hand-written reset and EPC alignment sequences.
module tb_cp0;

  logic        clk;
  logic        reset;
  logic [4:0]  RegAddr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic [31:0] VPC;
  logic        BDIn;
  logic [4:0]  ExcCodeIn;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic        Req;
  logic [31:0] EPCOut;

  int errors = 0;
  int checks = 0;

  cp0 #(.PRID(32'h0000_7f00)) dut (
    .clk      (clk),
    .reset    (reset),
    .RegAddr  (RegAddr),
    .WE       (WE),
    .Din      (Din),
    .Dout     (Dout),
    .VPC      (VPC),
    .BDIn     (BDIn),
    .ExcCodeIn(ExcCodeIn),
    .HWInt    (HWInt),
    .EXLClr   (EXLClr),
    .Req      (Req),
    .EPCOut   (EPCOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] vpc;
    logic        bd;
    logic [4:0]  exc;
    logic [5:0]  hw;
    logic        clr;
    logic        exp_req;
    logic [31:0] exp_dout;
    logic [31:0] exp_epc;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic [4:0] addr, input logic we, input logic [31:0] din,
                              input logic [31:0] vpc, input logic bd, input logic [4:0] exc,
                              input logic [5:0] hw, input logic clr, input logic exp_req,
                              input logic [31:0] exp_dout, input logic [31:0] exp_epc);
    vec_t v;
    v.addr = addr; v.we = we; v.din = din; v.vpc = vpc; v.bd = bd; v.exc = exc;
    v.hw = hw; v.clr = clr; v.exp_req = exp_req; v.exp_dout = exp_dout; v.exp_epc = exp_epc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    RegAddr = 5'd0; WE = 1'b0; Din = 32'd0; VPC = 32'd0; BDIn = 1'b0;
    ExcCodeIn = 5'd0; HWInt = 6'd0; EXLClr = 1'b0;
  endtask

  initial begin
    //                addr   we    din           vpc           bd    exc    hw         clr   req   dout          epc
    vecs[0]  = mk(5'd12, 1'b0, 32'h0,        32'h0,        1'b0, 5'd0,  6'b000000, 1'b0, 1'b0, 32'h0,        32'h0);
    vecs[1]  = mk(5'd13, 1'b0, 32'h0,        32'h0,        1'b0, 5'd0,  6'b000000, 1'b0, 1'b0, 32'h0,        32'h0);
    vecs[2]  = mk(5'd15, 1'b0, 32'h0,        32'h0,        1'b0, 5'd0,  6'b000000, 1'b0, 1'b0, 32'h0000_7f00, 32'h0);
    vecs[3]  = mk(5'd14, 1'b0, 32'h0,        32'h0,        1'b0, 5'd0,  6'b000000, 1'b0, 1'b0, 32'h0,        32'h0);
    // enable timer0: IM=000001, IE=1; no same-cycle bypass on Dout
    vecs[4]  = mk(5'd12, 1'b1, 32'h0000_0401, 32'h0,       1'b0, 5'd0,  6'b000000, 1'b0, 1'b0, 32'h0,        32'h0);
    vecs[5]  = mk(5'd12, 1'b0, 32'h0,        32'h0000_3008, 1'b0, 5'd0, 6'b000001, 1'b0, 1'b1, 32'h0000_0401, 32'h0);
    vecs[6]  = mk(5'd14, 1'b0, 32'h0,        32'h0,        1'b0, 5'd0,  6'b000001, 1'b0, 1'b0, 32'h0000_3008, 32'h0000_3008);
    vecs[7]  = mk(5'd12, 1'b0, 32'h0,        32'h0,        1'b0, 5'd0,  6'b000001, 1'b0, 1'b0, 32'h0000_0403, 32'h0000_3008);
    vecs[8]  = mk(5'd13, 1'b0, 32'h0,        32'h0,        1'b0, 5'd0,  6'b000001, 1'b1, 1'b0, 32'h0000_0400, 32'h0000_3008);
    // held line re-triggers right after EXL clears
    vecs[9]  = mk(5'd12, 1'b0, 32'h0,        32'h0000_3020, 1'b0, 5'd0, 6'b000001, 1'b0, 1'b1, 32'h0000_0401, 32'h0000_3008);
    vecs[10] = mk(5'd14, 1'b0, 32'h0,        32'h0,        1'b0, 5'd0,  6'b000000, 1'b1, 1'b0, 32'h0000_3020, 32'h0000_3020);
    vecs[11] = mk(5'd12, 1'b1, 32'h0,        32'h0,        1'b0, 5'd0,  6'b000000, 1'b0, 1'b0, 32'h0000_0401, 32'h0000_3020);
    // synchronous exception in a delay slot
    vecs[12] = mk(5'd13, 1'b0, 32'h0,        32'h0000_3010, 1'b1, 5'd4, 6'b000000, 1'b0, 1'b1, 32'h0,        32'h0000_3020);
    vecs[13] = mk(5'd13, 1'b0, 32'h0,        32'h0,        1'b0, 5'd0,  6'b000000, 1'b0, 1'b0, 32'h8000_0010, 32'h0000_300C);
    vecs[14] = mk(5'd14, 1'b0, 32'h0,        32'h0,        1'b0, 5'd0,  6'b000000, 1'b1, 1'b0, 32'h0000_300C, 32'h0000_300C);
    // mtc0 to Cause has no effect
    vecs[15] = mk(5'd13, 1'b1, 32'hffff_ffff, 32'h0,       1'b0, 5'd0,  6'b000000, 1'b0, 1'b0, 32'h8000_0010, 32'h0000_300C);
    vecs[16] = mk(5'd13, 1'b0, 32'h0,        32'h0,        1'b0, 5'd0,  6'b000000, 1'b0, 1'b0, 32'h8000_0010, 32'h0000_300C);
    vecs[17] = mk(5'd12, 1'b1, 32'h0000_0401, 32'h0,       1'b0, 5'd0,  6'b000000, 1'b0, 1'b0, 32'h0,        32'h0000_300C);
    // interrupt + exception + mtc0 EPC in one cycle: interrupt wins, write dropped
    vecs[18] = mk(5'd14, 1'b1, 32'hdead_beef, 32'h0000_3040, 1'b0, 5'd10, 6'b000001, 1'b0, 1'b1, 32'h0000_300C, 32'h0000_300C);
    vecs[19] = mk(5'd14, 1'b0, 32'h0,        32'h0,        1'b0, 5'd0,  6'b000001, 1'b0, 1'b0, 32'h0000_3040, 32'h0000_3040);
    vecs[20] = mk(5'd13, 1'b0, 32'h0,        32'h0,        1'b0, 5'd0,  6'b000001, 1'b0, 1'b0, 32'h0000_0400, 32'h0000_3040);
    // EXLClr beats the EXL bit of a same-cycle SR write; IM/IE take Din
    vecs[21] = mk(5'd12, 1'b1, 32'h0000_0C02, 32'h0,       1'b0, 5'd0,  6'b000000, 1'b1, 1'b0, 32'h0000_0403, 32'h0000_3040);
    vecs[22] = mk(5'd12, 1'b0, 32'h0,        32'h0,        1'b0, 5'd0,  6'b000000, 1'b0, 1'b0, 32'h0000_0C00, 32'h0000_3040);
    vecs[23] = mk(5'd12, 1'b1, 32'h0000_0403, 32'h0,       1'b0, 5'd0,  6'b000000, 1'b0, 1'b0, 32'h0000_0C00, 32'h0000_3040);
    vecs[24] = mk(5'd12, 1'b0, 32'h0,        32'h0,        1'b0, 5'd0,  6'b000001, 1'b0, 1'b0, 32'h0000_0403, 32'h0000_3040);

    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      if (i != 0) @(negedge clk);
      RegAddr = vecs[i].addr; WE = vecs[i].we; Din = vecs[i].din; VPC = vecs[i].vpc;
      BDIn = vecs[i].bd; ExcCodeIn = vecs[i].exc; HWInt = vecs[i].hw; EXLClr = vecs[i].clr;
      #1;
      check($sformatf("v%0d_req", i), {31'd0, Req}, {31'd0, vecs[i].exp_req});
      check($sformatf("v%0d_dout", i), Dout, vecs[i].exp_dout);
      check($sformatf("v%0d_epcout", i), EPCOut, vecs[i].exp_epc);
    end

    // Reset mid-handler (EXL=1, line held), competing with an SR write.
    @(negedge clk);
    idle_inputs();
    reset = 1'b1; HWInt = 6'b000001; WE = 1'b1; RegAddr = 5'd12; Din = 32'h0000_0401; EXLClr = 1'b1;
    @(negedge clk);
    reset = 1'b0; WE = 1'b0; EXLClr = 1'b0; Din = 32'd0;
    #1;
    check("rst_sr", Dout, 32'h0);
    check("rst_req", {31'd0, Req}, 32'h0);
    check("rst_epc", EPCOut, 32'h0);
    RegAddr = 5'd13;
    #1;
    check("rst_cause", Dout, 32'h0);
    RegAddr = 5'd3;
    #1;
    check("unmapped", Dout, 32'h0);
    RegAddr = 5'd15;
    #1;
    check("prid", Dout, 32'h0000_7f00);

    // Cause.IP follows HWInt; no Req because IE=0; exception still possible.
    @(negedge clk);
    RegAddr = 5'd13; HWInt = 6'b000100;
    #1;
    check("ip_load", Dout, 32'h0000_0400);
    check("masked_req", {31'd0, Req}, 32'h0);
    ExcCodeIn = 5'd12;
    #1;
    check("exc_req_after_rst", {31'd0, Req}, 32'h1);
    ExcCodeIn = 5'd0;

    // EPC write drops the low two bits; PRId write ignored.
    @(negedge clk);
    RegAddr = 5'd14; WE = 1'b1; Din = 32'h0000_1237;
    @(negedge clk);
    RegAddr = 5'd15; Din = 32'h1234_5678;
    #1;
    check("epc_align", EPCOut, 32'h0000_1234);
    @(negedge clk);
    WE = 1'b0;
    #1;
    check("prid_ro", Dout, 32'h0000_7f00);
    RegAddr = 5'd13;
    #1;
    check("ip_ext", Dout, 32'h0000_1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
